// File: rtl/modulation_segment_ctl_pkg.sv
// Shared types for the modulation segment sequencer.
package modulation_ctl_pkg;

  typedef enum logic {
    IMMEDIATE = 1'b0,
    ON_WRAP   = 1'b1
  } transition_mode_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PENDING = 2'd1,
    STOPPED = 2'd2
  } ctl_state_t;

  // Repetition value meaning "loop forever"
  localparam logic [15:0] REP_INFINITE = 16'hFFFF;

  localparam int NUM_SEG = 2;

endpackage

// File: rtl/modulation_segment_ctl_if.sv
// Segment-switch request handshake between host config and the sequencer.
interface modulation_segment_ctl_if;
  import modulation_ctl_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_segment;
  transition_mode_t req_mode;
  logic [15:0]      req_rep;

  modport master (output req_valid, req_segment, req_mode, req_rep, input req_ready);
  modport slave  (input req_valid, req_segment, req_mode, req_rep, output req_ready);

endinterface

// File: rtl/modulation_segment_ctl_seg_counter.sv
// Per-segment divider + index counter. wrap_o is the raw "this update wraps"
// strobe and ignores freeze_i, so the controller can decide to freeze on the
// very wrap that exhausts the loop without a combinational loop.
module modulation_seg_counter #(
  parameter int DEPTH_W = 15
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               update_i,
  input  logic [15:0]        freq_div_i,
  input  logic [DEPTH_W-1:0] cycle_i,
  input  logic               clear_i,
  input  logic               freeze_i,
  output logic [DEPTH_W-1:0] idx_o,
  output logic               wrap_o
);

  logic [15:0]        div_q, div_d;
  logic [DEPTH_W-1:0] idx_q, idx_d;
  logic               div_last;
  logic               idx_last;

  // FREQ_DIV of 0 or 1 advances on every tick; >= tolerates a shrunk divider
  assign div_last = (freq_div_i <= 16'd1) || (div_q >= freq_div_i - 16'd1);
  // > covers CYCLE shrinking under a running index
  assign idx_last = (idx_q >= cycle_i);
  assign wrap_o   = update_i && div_last && idx_last;
  assign idx_o    = idx_q;

  // Next-state: clear beats freeze beats normal counting
  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (clear_i) begin
      div_d = '0;
      idx_d = '0;
    end else if (!freeze_i && update_i) begin
      if (div_last) begin
        div_d = '0;
        idx_d = idx_last ? '0 : idx_q + DEPTH_W'(1);
      end else begin
        div_d = div_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/modulation_segment_ctl.sv
// Modulation segment sequencer: two free-running segment counters, host
// segment switching (immediate or on wrap) and loop repetition counting.
// Optional feature macro: MODULATION_LOOP_COUNT_EN (repetition counter and
// STOPPED state; without it playback is always infinite and stop_o is 0).
module modulation_segment_ctl
  import modulation_ctl_pkg::*;
#(
  parameter int DEPTH_W = 15
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            update_i,
  input  logic [NUM_SEG-1:0][15:0]        freq_div_i,
  input  logic [NUM_SEG-1:0][DEPTH_W-1:0] cycle_i,
  modulation_segment_ctl_if.slave         req_if,
  output logic [NUM_SEG-1:0][DEPTH_W-1:0] idx_o,
  output logic                            segment_o,
  output logic                            stop_o
);

  ctl_state_t         state_q, state_d;
  logic               seg_q, seg_d;
  logic               pend_seg_q, pend_seg_d;
  logic [NUM_SEG-1:0] clear, freeze, wrap;
  logic               accept;
  logic               act_wrap;
`ifdef MODULATION_LOOP_COUNT_EN
  logic [15:0]        rep_q, rep_d;
  logic [15:0]        pend_rep_q, pend_rep_d;
`else
  logic               unused_rep;
  assign unused_rep = ^req_if.req_rep;
`endif

  for (genvar s = 0; s < NUM_SEG; s++) begin : g_seg
    modulation_seg_counter #(.DEPTH_W(DEPTH_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .update_i   (update_i),
      .freq_div_i (freq_div_i[s]),
      .cycle_i    (cycle_i[s]),
      .clear_i    (clear[s]),
      .freeze_i   (freeze[s]),
      .idx_o      (idx_o[s]),
      .wrap_o     (wrap[s])
    );
  end

  assign req_if.req_ready = (state_q != PENDING);
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign act_wrap         = wrap[seg_q];
  assign segment_o        = seg_q;
  assign stop_o           = (state_q == STOPPED);

  // Switch/loop control: a new request beats a pending switch, which beats loop exhaust
  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    pend_seg_d = pend_seg_q;
    clear      = '0;
    freeze     = '0;
`ifdef MODULATION_LOOP_COUNT_EN
    rep_d      = rep_q;
    pend_rep_d = pend_rep_q;
    if (state_q == STOPPED) freeze[seg_q] = 1'b1;
`endif
    if (accept) begin
      if (req_if.req_mode == IMMEDIATE) begin
        clear[req_if.req_segment] = 1'b1;
        seg_d   = req_if.req_segment;
        state_d = RUN;
`ifdef MODULATION_LOOP_COUNT_EN
        rep_d   = req_if.req_rep;
`endif
      end else begin
        state_d    = PENDING;
        pend_seg_d = req_if.req_segment;
`ifdef MODULATION_LOOP_COUNT_EN
        pend_rep_d = req_if.req_rep;
`endif
      end
    end else if (state_q == PENDING && act_wrap) begin
      clear[pend_seg_q] = 1'b1;
      seg_d   = pend_seg_q;
      state_d = RUN;
`ifdef MODULATION_LOOP_COUNT_EN
      rep_d   = pend_rep_q;
`endif
    end
`ifdef MODULATION_LOOP_COUNT_EN
    else if (state_q == RUN && act_wrap && rep_q != REP_INFINITE) begin
      if (rep_q == 16'd0) begin
        // Hold the active index at CYCLE instead of wrapping
        state_d       = STOPPED;
        freeze[seg_q] = 1'b1;
      end else begin
        rep_d = rep_q - 16'd1;
      end
    end
`endif
  end

  // Control registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= RUN;
      seg_q      <= 1'b0;
      pend_seg_q <= 1'b0;
`ifdef MODULATION_LOOP_COUNT_EN
      rep_q      <= REP_INFINITE;
      pend_rep_q <= REP_INFINITE;
`endif
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      pend_seg_q <= pend_seg_d;
`ifdef MODULATION_LOOP_COUNT_EN
      rep_q      <= rep_d;
      pend_rep_q <= pend_rep_d;
`endif
    end
  end

endmodule
